// File: rtl/pump_cmd_decoder.sv
// Front-panel button conditioning and command decoding for pump_controller.
// Five sync+debounce lanes feed a one-command-per-cycle arbiter.
module pump_cmd_decoder #(
  parameter int DEBOUNCE_CYCLES = 20_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_frag,
  input  logic       btn_timer,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_manual,
  output logic [1:0] fragrance_select,
  output logic [1:0] timer_select,
  output logic       pump_on,
  output logic       pump_off,
  output logic       manual_on,
  output logic [2:0] pump_active
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  // lane order: frag, timer, start, stop, manual
  logic [4:0]    w_btn;
  logic [4:0]    r_s1;
  logic [4:0]    r_s2;
  logic [4:0]    r_stable;
  logic [4:0]    r_stable_d;
  logic [4:0]    w_press;
  logic [CW-1:0] r_cnt [5];

  assign w_btn = {btn_manual, btn_stop, btn_start,
                  btn_timer, btn_frag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_s1       <= w_btn;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      for (int i = 0; i < 5; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CMAX) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

  logic       w_frag;
  logic       w_timer;
  logic       w_start;
  logic       w_stop;
  logic       w_manual;
  logic       w_on;
  logic       w_off;
  logic       w_man;
  logic [1:0] w_frag_nxt;
  logic [1:0] w_timer_nxt;
  logic [2:0] w_set;
  logic [2:0] w_active_nxt;
  logic [1:0] r_frag;
  logic [1:0] r_timer;
  logic [2:0] r_active;
  logic       r_on;
  logic       r_off;
  logic       r_man;

  assign {w_manual, w_stop, w_start, w_timer, w_frag} = w_press;

  always_comb begin
    w_on         = w_start & ~w_stop;
    w_off        = w_stop;
    w_man        = w_manual & ~w_stop & ~w_start;
    w_frag_nxt   = r_frag;
    w_timer_nxt  = r_timer;
    w_set        = 3'b000;
    w_active_nxt = r_active;
    // frag advance yields to any command so the pump index is stable
    if (w_frag && !(w_start || w_stop || w_manual))
      w_frag_nxt = (r_frag == 2'd2) ? 2'd0 : r_frag + 2'd1;
    if (w_timer)
      w_timer_nxt = (r_timer == 2'd2) ? 2'd0 : r_timer + 2'd1;
    unique case (r_frag)
      2'd0:    w_set = 3'b001;
      2'd1:    w_set = 3'b010;
      2'd2:    w_set = 3'b100;
      default: w_set = 3'b000;
    endcase
    if (w_off)
      w_active_nxt = 3'b000;
    else if (w_on)
      w_active_nxt = r_active | w_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frag   <= '0;
      r_timer  <= '0;
      r_active <= '0;
      r_on     <= 1'b0;
      r_off    <= 1'b0;
      r_man    <= 1'b0;
    end else begin
      r_frag   <= w_frag_nxt;
      r_timer  <= w_timer_nxt;
      r_active <= w_active_nxt;
      r_on     <= w_on;
      r_off    <= w_off;
      r_man    <= w_man;
    end
  end

  assign fragrance_select = r_frag;
  assign timer_select     = r_timer;
  assign pump_on          = r_on;
  assign pump_off         = r_off;
  assign manual_on        = r_man;
  assign pump_active      = r_active;

endmodule

// File: tb/tb_pump_cmd_decoder.sv
// Scoreboard bench for pump_cmd_decoder with DEBOUNCE_CYCLES=4.
// Stimulus queues expected output events; a negedge monitor pops them.
module tb_pump_cmd_decoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;
  logic [1:0] fragrance_select;
  logic [1:0] timer_select;
  logic       pump_on;
  logic       pump_off;
  logic       manual_on;
  logic [2:0] pump_active;

  pump_cmd_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .btn_frag         (btn[0]),
    .btn_timer        (btn[1]),
    .btn_start        (btn[2]),
    .btn_stop         (btn[3]),
    .btn_manual       (btn[4]),
    .fragrance_select (fragrance_select),
    .timer_select     (timer_select),
    .pump_on          (pump_on),
    .pump_off         (pump_off),
    .manual_on        (manual_on),
    .pump_active      (pump_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         c;
    logic       on;
    logic       off;
    logic       man;
    logic [1:0] f;
    logic [1:0] t;
    logic [2:0] a;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // event appears D+3 edges after the edge following stimulus
  task automatic expect_ev(input logic on, input logic off,
                           input logic man, input logic [1:0] f,
                           input logic [1:0] t, input logic [2:0] a);
    ev_t e;
    e.c = cyc + D + 3;
    e.on = on; e.off = off; e.man = man;
    e.f = f; e.t = t; e.a = a;
    q.push_back(e);
  endtask

  task automatic press(input logic [4:0] m, input int hold,
                       input int rel);
    btn = btn | m;
    tick(hold);
    btn = btn & ~m;
    tick(rel);
  endtask

  task automatic check_zero(input string name);
    logic [9:0] got;
    got = {fragrance_select, timer_select, pump_on, pump_off,
           manual_on, pump_active};
    checks++;
    if (got !== 10'd0) begin
      errors++;
      $display("FAIL %s: outputs=%b required=%b", name, got, 10'd0);
    end
  endtask

  logic [1:0] p_f = '0;
  logic [1:0] p_t = '0;
  logic [2:0] p_a = '0;

  always @(negedge clk) begin
    ev_t g;
    ev_t e;
    if (rst_n && (pump_on || pump_off || manual_on ||
        fragrance_select != p_f || timer_select != p_t ||
        pump_active != p_a)) begin
      g.c = cyc; g.on = pump_on; g.off = pump_off;
      g.man = manual_on; g.f = fragrance_select;
      g.t = timer_select; g.a = pump_active;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cyc=%0d on=%b off=%b man=%b f=%0d t=%0d a=%b, required none",
                 g.c, g.on, g.off, g.man, g.f, g.t, g.a);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL event: got cyc=%0d on=%b off=%b man=%b f=%0d t=%0d a=%b, required cyc=%0d on=%b off=%b man=%b f=%0d t=%0d a=%b",
                   g.c, g.on, g.off, g.man, g.f, g.t, g.a,
                   e.c, e.on, e.off, e.man, e.f, e.t, e.a);
        end
      end
    end
    p_f = fragrance_select;
    p_t = timer_select;
    p_a = pump_active;
  end

  initial begin
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(3);

    expect_ev(0, 0, 0, 2'd1, 2'd0, 3'b000); press(5'b00001, 10, 10);
    expect_ev(0, 0, 0, 2'd2, 2'd0, 3'b000); press(5'b00001, 10, 10);
    expect_ev(0, 0, 0, 2'd0, 2'd0, 3'b000); press(5'b00001, 10, 10);

    expect_ev(0, 0, 0, 2'd0, 2'd1, 3'b000); press(5'b00010, 10, 10);
    expect_ev(0, 0, 0, 2'd0, 2'd2, 3'b000); press(5'b00010, 10, 10);
    expect_ev(0, 0, 0, 2'd0, 2'd0, 3'b000); press(5'b00010, 10, 10);

    expect_ev(0, 0, 0, 2'd1, 2'd0, 3'b000); press(5'b00001, 10, 10);
    expect_ev(0, 0, 0, 2'd2, 2'd0, 3'b000); press(5'b00001, 10, 10);

    expect_ev(1, 0, 0, 2'd2, 2'd0, 3'b100); press(5'b00100, 50, 10);

    btn[4] = 1'b1; tick(3);
    btn[4] = 1'b0; tick(2);
    btn[4] = 1'b1; tick(3);
    btn[4] = 1'b0; tick(12);

    expect_ev(0, 0, 1, 2'd2, 2'd0, 3'b100); press(5'b10000, 8, 10);

    expect_ev(0, 0, 0, 2'd0, 2'd0, 3'b100); press(5'b00001, 10, 10);
    expect_ev(1, 0, 0, 2'd0, 2'd0, 3'b101); press(5'b00100, 10, 10);
    expect_ev(0, 1, 0, 2'd0, 2'd0, 3'b000); press(5'b01100, 10, 10);
    expect_ev(1, 0, 0, 2'd0, 2'd0, 3'b001); press(5'b00101, 10, 10);
    expect_ev(0, 0, 1, 2'd0, 2'd1, 3'b001); press(5'b10010, 10, 10);

    btn[1] = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    tick(3);
    check_zero("held_in_reset");
    expect_ev(0, 0, 0, 2'd0, 2'd1, 3'b000);
    rst_n = 1'b1;
    tick(20);
    btn[1] = 1'b0;
    tick(20);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: pending=%0d required=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pump_cmd_decoder.md
# pump_cmd_decoder

Front-panel command decoder that sits directly upstream of `pump_controller`. It synchronises and debounces five raw push-buttons, then maintains the `fragrance_select` and `timer_select` registers. It emits the single-cycle `pump_on`, `pump_off` and `manual_on` command pulses that `pump_controller` consumes. It also tracks which fragrances have been started (`pump_active`) for the LCD status page.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20_000: consecutive stable cycles required before a button level is accepted (20 ms at 1 MHz). Legal range is 1 to 2^20.

Ports:
- `clk`  input  1  system clock (1 MHz in the product).
- `rst_n`  input  1  reset, asynchronous assert, active-low. One clock domain; there is no other clock.
- `btn_frag`  input  1  raw, asynchronous, active-high. Advances the fragrance selection.
- `btn_timer`  input  1  raw, asynchronous, active-high. Advances the timer period selection.
- `btn_start`  input  1  raw, active-high. Starts the selected fragrance pump.
- `btn_stop`  input  1  raw, active-high. Stops all pumps.
- `btn_manual`  input  1  raw, active-high. Requests a forced pulse on the selected pump.
- `fragrance_select`  output  2  currently selected fragrance, 0..2. Never 3.
- `timer_select`  output  2  currently selected period index, 0..2. Never 3.
- `pump_on`  output  1  one-cycle start command.
- `pump_off`  output  1  one-cycle stop-all command.
- `manual_on`  output  1  one-cycle manual-pulse command.
- `pump_active`  output  3  bit i is set when fragrance i has been started since the last stop.

## Operation
- **Per-button conditioning** (five identical lanes):
  - 2-FF synchroniser `s1`→`s2`.
  - Debounce counter `cnt`, width clog2(DEBOUNCE_CYCLES)+1.
  - Accepted level `stable`.
  - Registered press detector `stable & ~stable_d`.
- **Debounce rule:**
  - If `s2 == stable`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= s2` and `cnt <= 0`.
  - Else `cnt <= cnt+1`.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is fully rejected.
- **Press events:** only rising edges of `stable` (press) generate events. A release generates nothing.
- **Command arbitration:** at most one command pulse is issued per cycle. When press events coincide in the same cycle:
  - Priority is stop > start > manual.
  - Losing command events are dropped, not queued.
- **Selection updates:**
  - A frag press advances `fragrance_select` 0→1→2→0.
  - A timer press advances `timer_select` 0→1→2→0.
  - If any command event (stop, start or manual) is decoded in the same cycle as a frag press, the frag advance is dropped. This keeps `fragrance_select` constant on the cycle `pump_controller` samples the command.
  - A timer press is never dropped.
- **`pump_active` updates:**
  - On an issued `pump_on`, set bit[`fragrance_select`].
  - On an issued `pump_off`, clear all 3 bits.
  - `manual_on` leaves it unchanged.
  - Starting an already-active fragrance is legal; the bit stays 1 and `pump_on` is still issued.

## Timing
- **Reset values:** all outputs are 0, and all `s1`, `s2`, `stable`, `stable_d` and `cnt` registers are 0. Reset takes effect asynchronously at any point, including mid-debounce; a partially counted press is discarded.
- **Latency:**
  - Input rises and stays high from before clock edge E0: `s1`=1 at E0, `s2`=1 at E1.
  - `stable`=1 at E(1+DEBOUNCE_CYCLES).
  - Command or selection output changes at E(2+DEBOUNCE_CYCLES).
  - With DEBOUNCE_CYCLES=4, the output changes 6 edges after first sampling.
- **Pulse shape:** `pump_on`, `pump_off` and `manual_on` are high for exactly one cycle per accepted press, whatever the hold duration.
- **Update alignment:**
  - `fragrance_select` and `timer_select` update on the same edge a pulse would appear.
  - `pump_active` updates on the same edge as the `pump_on`/`pump_off` it reflects.
- **Button held through reset release:** the press is treated as new and yields one event DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- **Minimum press-to-press spacing:** about 2×DEBOUNCE_CYCLES cycles (debounced release, then debounced press). No other throughput limit applies.

## Test plan
(DEBOUNCE_CYCLES=4 throughout.)
- Reset, then press `btn_frag` three times (each held 10 cycles, released 10 cycles) → `fragrance_select` goes 1, 2, 0. No command pulses occur.
- Press `btn_start` with `fragrance_select`=2, held 50 cycles → exactly one `pump_on` pulse, 6 edges after first sampling. `pump_active`=3'b100 on the same edge.
- Toggle `btn_manual` high for 3 cycles, low for 2, high for 3 → no `manual_on`. Then hold it for 8 cycles → one `manual_on`, with `pump_active` unchanged.
- Press `btn_start` and `btn_stop` in the same cycle with `pump_active`=3'b101 → only `pump_off` is issued and `pump_active`=0. No `pump_on` is issued.
- Press `btn_frag` and `btn_start` in the same cycle with `fragrance_select`=0 → `pump_on` is issued, `fragrance_select` stays 0, and `pump_active`[0]=1.
- Assert `rst_n`=0 two cycles into a debounce of `btn_timer`, then release reset with the button still held → outputs are 0 during reset. One `timer_select` advance to 1 occurs 6 edges after reset release.
